// File: rtl/mc_ctrl_ws_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_ws_pkg
// Shared definitions for the wait-state multicycle MIPS controller:
//   - mc_state_e   : controller state encoding
//   - alu_cls_e    : what kind of ALU operation a state asks for
//   - OP_*         : primary opcodes decoded by the controller
//   - FUNCT_*      : R-type function fields
//   - ALU_CTRL_*   : ALU operation codes driven on alu_ctrl_sig
//   - PC_SRC_* / SRCB_* : datapath mux selections
// ---------------------------------------------------------------------------
package mc_ctrl_ws_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_RTEX,
        ST_RTWB,
        ST_BEQEX,
        ST_BNEEX,
        ST_ADDIEX,
        ST_ADDIWB,
        ST_JEX,
        ST_FAULT
    } mc_state_e;

    // ALU request class: fixed add, fixed subtract, or decode from funct
    typedef enum logic [1:0] {
        ALU_CLS_ADD,
        ALU_CLS_SUB,
        ALU_CLS_FUNCT
    } alu_cls_e;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function fields
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALU_CTRL_AND = 3'b000;
    localparam logic [2:0] ALU_CTRL_OR  = 3'b001;
    localparam logic [2:0] ALU_CTRL_ADD = 3'b010;
    localparam logic [2:0] ALU_CTRL_SUB = 3'b110;
    localparam logic [2:0] ALU_CTRL_SLT = 3'b111;

    // PC source mux
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // ALU B-operand mux
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SEXT    = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

    // States that hold a memory request open and wait for mem_ready
    function automatic logic is_mem_wait(input mc_state_e s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

    // Last state of an instruction; leaving it for FETCH retires the instruction
    function automatic logic is_final(input mc_state_e s);
        return (s == ST_MEMWR)  || (s == ST_MEMWB) || (s == ST_RTWB) ||
               (s == ST_BEQEX)  || (s == ST_BNEEX) || (s == ST_ADDIWB) ||
               (s == ST_JEX);
    endfunction

endpackage

// File: rtl/mc_ctrl_ws_alu_decoder.sv
// ---------------------------------------------------------------------------
// mc_ctrl_ws_alu_decoder
// Combinational ALU control decode.
//   alu_cls      in  : operation class requested by the current state
//   funct        in  : R-type function field (used only for ALU_CLS_FUNCT)
//   alu_ctrl_sig out : ALU operation code
// Unrecognised function fields fall back to add; that is not an error.
// ---------------------------------------------------------------------------
module mc_ctrl_ws_alu_decoder
    import mc_ctrl_ws_pkg::*;
(
    input  alu_cls_e    alu_cls,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_ctrl_sig
);

    always_comb begin
        alu_ctrl_sig = ALU_CTRL_ADD;
        unique case (alu_cls)
            ALU_CLS_ADD: alu_ctrl_sig = ALU_CTRL_ADD;
            ALU_CLS_SUB: alu_ctrl_sig = ALU_CTRL_SUB;
            ALU_CLS_FUNCT: begin
                unique case (funct)
                    FUNCT_ADD: alu_ctrl_sig = ALU_CTRL_ADD;
                    FUNCT_SUB: alu_ctrl_sig = ALU_CTRL_SUB;
                    FUNCT_AND: alu_ctrl_sig = ALU_CTRL_AND;
                    FUNCT_OR:  alu_ctrl_sig = ALU_CTRL_OR;
                    FUNCT_SLT: alu_ctrl_sig = ALU_CTRL_SLT;
                    default:   alu_ctrl_sig = ALU_CTRL_ADD;
                endcase
            end
            default: alu_ctrl_sig = ALU_CTRL_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_ws.sv
// ---------------------------------------------------------------------------
// mc_ctrl_ws
// Multicycle MIPS main controller with memory wait states, bus timeout,
// BNE/ADDI/J support and a retired-instruction counter.
//
// Parameters
//   TIMEOUT : not-ready cycles a memory state tolerates before FAULT (1..255)
//   CNT_W   : width of the retired-instruction counter
//   EN_EXT  : 1 = decode ADDI/J/BNE, 0 = those opcodes fault
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   op, funct, zero       : decoder fields and ALU zero flag
//   mem_ready             : memory completes the current access this cycle
//   hold                  : freeze request (state and counters frozen)
//   mem_req, mem_write    : memory handshake / write strobe
//   i_or_d                : memory address select (0 PC, 1 ALUOut)
//   ireg_enab, pc_enab    : IR / PC load strobes
//   pc_src                : PC source select
//   mem_to_reg, reg_dst   : writeback selects
//   reg_write             : register-file write strobe
//   alu_srcA, alu_srcB    : ALU operand selects
//   alu_ctrl_sig          : ALU operation
//   instret               : retired-instruction count (wraps)
//   fault                 : sticky fault flag, cleared only by reset
// ---------------------------------------------------------------------------
module mc_ctrl_ws
    import mc_ctrl_ws_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32,
    parameter bit EN_EXT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    input  logic             hold,
    output logic             mem_req,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ireg_enab,
    output logic             pc_enab,
    output logic [1:0]       pc_src,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_srcA,
    output logic [1:0]       alu_srcB,
    output logic [2:0]       alu_ctrl_sig,
    output logic [CNT_W-1:0] instret,
    output logic             fault
);

    localparam int               TO_W        = 8;
    // The wait that would bring the count to TIMEOUT is the one that faults
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_ONE      = TO_W'(1);
    localparam logic [CNT_W-1:0] INSTRET_ONE = CNT_W'(1);

    mc_state_e        state_reg, state_next;
    logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
    logic [CNT_W-1:0] instret_reg, instret_next;
    alu_cls_e         alu_cls;
    logic             ready_q;
    logic             wait_expired;

    // mem_ready only counts when not frozen
    assign ready_q      = mem_ready & ~hold;
    assign wait_expired = ~hold & ~mem_ready & (to_cnt_reg == TO_LAST);

    // ------------------------------------------------------------------
    // State register and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_FETCH;
            to_cnt_reg  <= '0;
            instret_reg <= '0;
        end else begin
            state_reg   <= state_next;
            to_cnt_reg  <= to_cnt_next;
            instret_reg <= instret_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ireg_enab  = 1'b0;
        pc_enab    = 1'b0;
        pc_src     = PC_SRC_ALU;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_srcA   = 1'b0;
        alu_srcB   = SRCB_B;
        alu_cls    = ALU_CLS_ADD;

        unique case (state_reg)
            ST_FETCH: begin
                mem_req  = 1'b1;
                alu_srcB = SRCB_FOUR;
                if (ready_q) begin
                    ireg_enab  = 1'b1;
                    pc_enab    = 1'b1;
                    state_next = ST_DECODE;
                end else if (wait_expired) begin
                    state_next = ST_FAULT;
                end
            end
            ST_DECODE: begin
                // Branch target is computed speculatively here
                alu_srcB = SRCB_SEXT_SH;
                unique case (op)
                    OP_LW, OP_SW: state_next = ST_MEMADR;
                    OP_RTYPE:     state_next = ST_RTEX;
                    OP_BEQ:       state_next = ST_BEQEX;
                    OP_BNE:       state_next = EN_EXT ? ST_BNEEX  : ST_FAULT;
                    OP_ADDI:      state_next = EN_EXT ? ST_ADDIEX : ST_FAULT;
                    OP_J:         state_next = EN_EXT ? ST_JEX    : ST_FAULT;
                    default:      state_next = ST_FAULT;
                endcase
            end
            ST_MEMADR: begin
                alu_srcA   = 1'b1;
                alu_srcB   = SRCB_SEXT;
                state_next = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (ready_q) begin
                    state_next = ST_MEMWB;
                end else if (wait_expired) begin
                    state_next = ST_FAULT;
                end
            end
            ST_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (ready_q) begin
                    state_next = ST_FETCH;
                end else if (wait_expired) begin
                    state_next = ST_FAULT;
                end
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = ST_FETCH;
            end
            ST_RTEX: begin
                alu_srcA   = 1'b1;
                alu_cls    = ALU_CLS_FUNCT;
                state_next = ST_RTWB;
            end
            ST_RTWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                state_next = ST_FETCH;
            end
            ST_BEQEX: begin
                alu_srcA   = 1'b1;
                alu_cls    = ALU_CLS_SUB;
                pc_src     = PC_SRC_ALUOUT;
                pc_enab    = zero;
                state_next = ST_FETCH;
            end
            ST_BNEEX: begin
                alu_srcA   = 1'b1;
                alu_cls    = ALU_CLS_SUB;
                pc_src     = PC_SRC_ALUOUT;
                pc_enab    = ~zero;
                state_next = ST_FETCH;
            end
            ST_ADDIEX: begin
                alu_srcA   = 1'b1;
                alu_srcB   = SRCB_SEXT;
                state_next = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                reg_write  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_JEX: begin
                pc_src     = PC_SRC_JUMP;
                pc_enab    = 1'b1;
                state_next = ST_FETCH;
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_FAULT;
            end
        endcase

        // Freeze: keep state, kill every write/enable, keep any open request
        if (hold) begin
            state_next = state_reg;
            ireg_enab  = 1'b0;
            pc_enab    = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
        end

        // Nothing may strobe while reset is asserted, even though the
        // state register already sits in FETCH
        if (!rst_n) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ireg_enab = 1'b0;
            pc_enab   = 1'b0;
            reg_write = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Timeout and retire counters
    // ------------------------------------------------------------------
    always_comb begin
        to_cnt_next  = to_cnt_reg;
        instret_next = instret_reg;
        if (!hold) begin
            // Any state change restarts the wait count, so every memory
            // wait state is entered with a cleared counter
            if (state_next != state_reg) begin
                to_cnt_next = '0;
            end else if (is_mem_wait(state_reg) && !mem_ready) begin
                to_cnt_next = to_cnt_reg + TO_ONE;
            end
            if ((state_next == ST_FETCH) && is_final(state_reg)) begin
                instret_next = instret_reg + INSTRET_ONE;
            end
        end
    end

    mc_ctrl_ws_alu_decoder u_alu_decoder (
        .alu_cls      (alu_cls),
        .funct        (funct),
        .alu_ctrl_sig (alu_ctrl_sig)
    );

    assign instret = instret_reg;
    assign fault   = (state_reg == ST_FAULT);

endmodule

// File: tb/tb_mc_ctrl_ws.sv
`timescale 1ns/1ps
module tb_mc_ctrl_ws;

    localparam int TO    = 4;
    localparam int NE_W  = 3;

    // Opcodes / functs (independent of the design package)
    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_J    = 6'b000010;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_BNE  = 6'b000101;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_BAD  = 6'b111111;

    // Bit positions in the observed control vector
    localparam int B_REQ = 15, B_WR = 14, B_IOD = 13, B_IR = 12, B_PC = 11;
    localparam int B_PCSRC = 9, B_M2R = 8, B_DST = 7, B_RW = 6, B_SA = 5;
    localparam int B_SB = 3, B_ALU = 0;
    localparam logic [15:0] STROBE_MASK = 16'hD840;

    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWR, P_MEMWB, P_RTEX, P_RTWB,
        P_BEQ, P_BNE, P_ADDIEX, P_ADDIWB, P_JEX, P_FAULT
    } phase_e;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] op = '0, funct = '0;
    logic zero = 1'b0, mem_ready = 1'b0, hold = 1'b0;

    logic mem_req, mem_write, i_or_d, ireg_enab, pc_enab, mem_to_reg, reg_dst;
    logic reg_write, alu_srcA, fault;
    logic [1:0] pc_src, alu_srcB;
    logic [2:0] alu_ctrl_sig;
    logic [31:0] instret;

    logic ne_mem_req, ne_mem_write, ne_i_or_d, ne_ireg_enab, ne_pc_enab;
    logic ne_mem_to_reg, ne_reg_dst, ne_reg_write, ne_alu_srcA, ne_fault;
    logic [1:0] ne_pc_src, ne_alu_srcB;
    logic [2:0] ne_alu_ctrl_sig;
    logic [NE_W-1:0] ne_instret;

    int checks = 0;
    int errors = 0;
    int model_instret = 0;
    int cyc = 0;
    logic [15:0] exp_val, exp_msk;
    logic [15:0] obs;

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_write, i_or_d, ireg_enab, pc_enab, pc_src,
                  mem_to_reg, reg_dst, reg_write, alu_srcA, alu_srcB, alu_ctrl_sig};

    mc_ctrl_ws #(.TIMEOUT(TO), .CNT_W(32), .EN_EXT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .hold(hold), .mem_req(mem_req),
        .mem_write(mem_write), .i_or_d(i_or_d), .ireg_enab(ireg_enab),
        .pc_enab(pc_enab), .pc_src(pc_src), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_srcA(alu_srcA),
        .alu_srcB(alu_srcB), .alu_ctrl_sig(alu_ctrl_sig), .instret(instret),
        .fault(fault)
    );

    mc_ctrl_ws #(.TIMEOUT(TO), .CNT_W(NE_W), .EN_EXT(1'b0)) dut_ne (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .hold(hold), .mem_req(ne_mem_req),
        .mem_write(ne_mem_write), .i_or_d(ne_i_or_d), .ireg_enab(ne_ireg_enab),
        .pc_enab(ne_pc_enab), .pc_src(ne_pc_src), .mem_to_reg(ne_mem_to_reg),
        .reg_dst(ne_reg_dst), .reg_write(ne_reg_write), .alu_srcA(ne_alu_srcA),
        .alu_srcB(ne_alu_srcB), .alu_ctrl_sig(ne_alu_ctrl_sig),
        .instret(ne_instret), .fault(ne_fault)
    );

    // ---------------- reference model ----------------
    function automatic logic [2:0] ref_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2a:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic void fld(input int lsb, input int w, input logic [2:0] v);
        for (int k = 0; k < w; k++) begin
            exp_val[lsb+k] = v[k];
            exp_msk[lsb+k] = 1'b1;
        end
    endfunction

    // Expected control values for one cycle of a given phase; fields the
    // instruction step leaves unspecified are masked out
    function automatic void expect_set(input phase_e ph, input logic rdy,
                                       input logic hld);
        exp_val = '0;
        exp_msk = STROBE_MASK;
        case (ph)
            P_FETCH: begin
                fld(B_REQ, 1, 3'd1); fld(B_IOD, 1, 3'd0); fld(B_SA, 1, 3'd0);
                fld(B_SB, 2, 3'd1); fld(B_ALU, 3, 3'b010);
                if (rdy) begin
                    fld(B_IR, 1, 3'd1); fld(B_PC, 1, 3'd1); fld(B_PCSRC, 2, 3'd0);
                end
            end
            P_DECODE: begin fld(B_SA, 1, 3'd0); fld(B_SB, 2, 3'd3); fld(B_ALU, 3, 3'b010); end
            P_MEMADR: begin fld(B_SA, 1, 3'd1); fld(B_SB, 2, 3'd2); fld(B_ALU, 3, 3'b010); end
            P_MEMRD:  begin fld(B_REQ, 1, 3'd1); fld(B_IOD, 1, 3'd1); end
            P_MEMWR:  begin fld(B_REQ, 1, 3'd1); fld(B_WR, 1, 3'd1); fld(B_IOD, 1, 3'd1); end
            P_MEMWB:  begin fld(B_RW, 1, 3'd1); fld(B_DST, 1, 3'd0); fld(B_M2R, 1, 3'd1); end
            P_RTEX:   begin fld(B_SA, 1, 3'd1); fld(B_SB, 2, 3'd0); fld(B_ALU, 3, ref_alu(funct)); end
            P_RTWB:   begin fld(B_RW, 1, 3'd1); fld(B_DST, 1, 3'd1); fld(B_M2R, 1, 3'd0); end
            P_BEQ, P_BNE: begin
                fld(B_SA, 1, 3'd1); fld(B_SB, 2, 3'd0); fld(B_ALU, 3, 3'b110);
                fld(B_PCSRC, 2, 3'd1);
                fld(B_PC, 1, {2'b00, (ph == P_BEQ) ? zero : !zero});
            end
            P_ADDIEX: begin fld(B_SA, 1, 3'd1); fld(B_SB, 2, 3'd2); fld(B_ALU, 3, 3'b010); end
            P_ADDIWB: begin fld(B_RW, 1, 3'd1); fld(B_DST, 1, 3'd0); fld(B_M2R, 1, 3'd0); end
            P_JEX:    begin fld(B_PCSRC, 2, 3'd2); fld(B_PC, 1, 3'd1); end
            default:  ;
        endcase
        if (hld) begin
            exp_val[B_IR] = 1'b0; exp_val[B_PC] = 1'b0;
            exp_val[B_RW] = 1'b0; exp_val[B_WR] = 1'b0;
        end
    endfunction

    // One clock cycle: drive, sample at negedge, compare, advance
    task automatic step(input phase_e ph, input logic rdy, input logic hld);
        mem_ready = rdy;
        hold      = hld;
        @(negedge clk);
        expect_set(ph, rdy & ~hld, hld);
        checks++;
        if ((obs & exp_msk) !== (exp_val & exp_msk)) begin
            errors++;
            $display("FAIL ctrl %s cyc %0d: got %b need %b (mask %b)",
                     ph.name(), cyc, obs, exp_val, exp_msk);
        end
        checks++;
        if (instret !== 32'(model_instret)) begin
            errors++;
            $display("FAIL instret %s cyc %0d: got %0d need %0d", ph.name(), cyc,
                     instret, model_instret);
        end
        checks++;
        if (fault !== (ph == P_FAULT)) begin
            errors++;
            $display("FAIL fault %s cyc %0d: got %b need %b", ph.name(), cyc,
                     fault, (ph == P_FAULT));
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction through the model; fw/mw are not-ready cycles
    // before completion in FETCH / the data access. Returns 1 if it faulted.
    task automatic exec_instr(input logic [5:0] o, input logic [5:0] fn,
                              input logic z, input int fw, input int mw,
                              input int hold_idx, input int hold_len,
                              output logic faulted);
        phase_e ph[$];
        int w;
        int c0;
        c0 = cyc;
        faulted = 1'b0;
        op = o; funct = fn; zero = z;
        ph.push_back(P_FETCH);
        ph.push_back(P_DECODE);
        case (o)
            OPC_LW:   begin ph.push_back(P_MEMADR); ph.push_back(P_MEMRD); ph.push_back(P_MEMWB); end
            OPC_SW:   begin ph.push_back(P_MEMADR); ph.push_back(P_MEMWR); end
            OPC_R:    begin ph.push_back(P_RTEX); ph.push_back(P_RTWB); end
            OPC_BEQ:  ph.push_back(P_BEQ);
            OPC_BNE:  ph.push_back(P_BNE);
            OPC_ADDI: begin ph.push_back(P_ADDIEX); ph.push_back(P_ADDIWB); end
            OPC_J:    ph.push_back(P_JEX);
            default:  ph.push_back(P_FAULT);
        endcase
        foreach (ph[i]) begin
            if (i == hold_idx) repeat (hold_len) step(ph[i], 1'($urandom), 1'b1);
            if (faulted) begin
            end else if (ph[i] == P_FAULT) begin
                faulted = 1'b1;
            end else if (ph[i] == P_FETCH || ph[i] == P_MEMRD || ph[i] == P_MEMWR) begin
                w = (ph[i] == P_FETCH) ? fw : mw;
                for (int k = 0; k < w && k < TO; k++) step(ph[i], 1'b0, 1'b0);
                if (w >= TO) faulted = 1'b1;
                else step(ph[i], 1'b1, 1'b0);
            end else begin
                step(ph[i], 1'($urandom), 1'b0);
            end
        end
        if (faulted) repeat (3) step(P_FAULT, 1'($urandom), 1'b0);
        else model_instret++;
        $display("instr op=%b funct=%b zero=%b fw=%0d mw=%0d hold@%0d x%0d cycles=%0d -> %s instret=%0d",
                 o, fn, z, fw, mw, hold_idx, hold_len, cyc - c0,
                 faulted ? "fault" : "retired", instret);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hold = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ((obs & STROBE_MASK) !== 16'h0) begin
            errors++;
            $display("FAIL reset_strobes: got %b need 0 under mask %b", obs, STROBE_MASK);
        end
        checks++;
        if (instret !== 32'd0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: instret=%0d fault=%b need 0/0", instret, fault);
        end
        checks++;
        if (ne_instret !== '0 || ne_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_ne: instret=%0d fault=%b need 0/0", ne_instret, ne_fault);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        model_instret = 0;
        $display("reset applied");
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_lw();
        logic f;
        exec_instr(OPC_LW, 6'h00, 1'b0, 0, 0, -1, 0, f);
        hold = 1'b1;
        @(negedge clk);
        checks++;
        if (instret !== 32'd1) begin
            errors++;
            $display("FAIL lw_instret: got %0d need 1", instret);
        end
        @(posedge clk); #1;
        hold = 1'b0;
    endtask

    task automatic test_sw_wait();
        logic f;
        exec_instr(OPC_SW, 6'h00, 1'b0, 1, 3, -1, 0, f);
    endtask

    task automatic test_branches();
        logic f;
        exec_instr(OPC_BNE, 6'h00, 1'b0, 0, 0, -1, 0, f);
        exec_instr(OPC_BNE, 6'h00, 1'b1, 0, 0, -1, 0, f);
        exec_instr(OPC_BEQ, 6'h00, 1'b1, 0, 0, -1, 0, f);
        exec_instr(OPC_BEQ, 6'h00, 1'b0, 0, 0, -1, 0, f);
        exec_instr(OPC_J,   6'h00, 1'b0, 0, 0, -1, 0, f);
        exec_instr(OPC_ADDI, 6'h00, 1'b0, 0, 0, -1, 0, f);
    endtask

    task automatic test_hold();
        logic f;
        exec_instr(OPC_R, 6'h22, 1'b0, 0, 0, 3, 5, f);   // held in RTWB
        exec_instr(OPC_LW, 6'h00, 1'b0, 1, 2, 0, 3, f);  // held in FETCH
        exec_instr(OPC_SW, 6'h00, 1'b0, 0, 1, 3, 2, f);  // held in MEMWR
    endtask

    task automatic test_timeout();
        logic f;
        exec_instr(OPC_LW, 6'h00, 1'b0, TO - 1, TO - 1, -1, 0, f);  // boundary: completes
        checks++;
        if (f !== 1'b0) begin
            errors++;
            $display("FAIL to_boundary: faulted=%b need 0", f);
        end
        exec_instr(OPC_R, 6'h20, 1'b0, TO, 0, -1, 0, f);            // FETCH stuck
        checks++;
        if (f !== 1'b1) begin
            errors++;
            $display("FAIL to_fetch: faulted=%b need 1", f);
        end
        do_reset();
        exec_instr(OPC_LW, 6'h00, 1'b0, 0, TO, -1, 0, f);           // MEMRD stuck
        do_reset();
        exec_instr(OPC_SW, 6'h00, 1'b0, 0, TO + 2, -1, 0, f);       // MEMWR stuck
        do_reset();
    endtask

    task automatic test_unknown_op();
        logic f;
        exec_instr(OPC_BAD, 6'h00, 1'b0, 0, 0, -1, 0, f);
        do_reset();
    endtask

    task automatic test_en_ext();
        logic f;
        int ne_exp;
        do_reset();
        for (int i = 0; i < 9; i++)
            exec_instr(OPC_R, 6'($urandom), 1'($urandom), 0, 0, -1, 0, f);
        ne_exp = 9 % (1 << NE_W);
        checks++;
        if (ne_instret !== NE_W'(ne_exp)) begin
            errors++;
            $display("FAIL ne_wrap: got %0d need %0d", ne_instret, ne_exp);
        end
        exec_instr(OPC_ADDI, 6'h00, 1'b0, 0, 0, -1, 0, f);
        checks++;
        if (ne_fault !== 1'b1 || ne_instret !== NE_W'(ne_exp)) begin
            errors++;
            $display("FAIL ne_addi: fault=%b instret=%0d need 1/%0d", ne_fault,
                     ne_instret, ne_exp);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic f;
        logic [5:0] ops [7];
        logic [5:0] fns [6];
        ops = '{OPC_LW, OPC_SW, OPC_R, OPC_BEQ, OPC_BNE, OPC_ADDI, OPC_J};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h3f};
        for (int i = 0; i < 40; i++) begin
            int hi, hl;
            hi = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 0)) : -1;
            hl = int'($urandom_range(3, 1));
            exec_instr(ops[$urandom_range(6, 0)], fns[$urandom_range(5, 0)],
                       1'($urandom), int'($urandom_range(TO - 1, 0)),
                       int'($urandom_range(TO - 1, 0)), hi, hl, f);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_branches();
        test_hold();
        test_timeout();
        test_unknown_op();
        test_en_ext();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_ws.md
Name: mc_ctrl_ws

Overview:
Multicycle MIPS main controller with memory wait-state support. It generalises the existing fixed-timing controller in four ways: a req/ready memory handshake, a bus-timeout fault, a BNE/ADDI/J opcode set, and a retired-instruction counter. It sits in cpu between decoder and datapath. The datapath is unchanged except that it now receives pc_enab and mem_req from this block.

Parameters:
TIMEOUT, 16, max cycles a memory state waits for mem_ready before FAULT (1..255)
CNT_W, 32, width of retired-instruction counter
EN_EXT, 1, 1 = decode ADDI/J/BNE; 0 = those opcodes go to FAULT

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
op  in  6  opcode from decoder
funct  in  6  function field from decoder
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
hold  in  1  external freeze; FSM stays in current state
mem_req  out  1  memory access request
mem_write  out  1  write strobe (qualified by mem_req)
i_or_d  out  1  0 = PC address, 1 = ALUOut address
ireg_enab  out  1  instruction register load
pc_enab  out  1  PC load
pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target
mem_to_reg  out  1  writeback selects memory data
reg_dst  out  1  1 = rd, 0 = rt
reg_write  out  1  register-file write
alu_srcA  out  1  0 = PC, 1 = A
alu_srcB  out  2  00 B, 01 const 4, 10 signext, 11 signext<<2
alu_ctrl_sig  out  3  ALU operation
instret  out  CNT_W  retired-instruction count
fault  out  1  sticky fault flag

Behaviour:
- Reset (async, rst_n=0): state=FETCH, instret=0, fault=0, timeout counter=0. All strobes are 0 during reset.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB, BEQEX, BNEEX, ADDIEX, ADDIWB, JEX, FAULT.
- FETCH: mem_req=1, i_or_d=0, alu_srcA=0, alu_srcB=01, add.
  - While mem_ready=0: stay in FETCH; ireg_enab=0, pc_enab=0.
  - On the cycle mem_ready=1: ireg_enab=1, pc_enab=1, pc_src=00, then go to DECODE.
- DECODE: alu_srcA=0, alu_srcB=11, add (branch target precompute). Next state by op:
  - LW or SW -> MEMADR
  - R-type -> RTEX
  - BEQ -> BEQEX
  - BNE -> BNEEX
  - ADDI -> ADDIEX
  - J -> JEX
  - anything else -> FAULT
- MEMADR: alu_srcA=1, alu_srcB=10, add. Next is MEMRD for LW, MEMWR for SW.
- MEMRD and MEMWR:
  - mem_req=1, i_or_d=1; MEMWR also drives mem_write=1.
  - Both wait on mem_ready like FETCH.
  - When mem_ready=1: MEMRD -> MEMWB; MEMWR -> FETCH (retire).
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, then FETCH (retire).
- RTEX: alu_srcA=1, alu_srcB=00, alu_ctrl from funct, then RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH (retire).
- BEQEX and BNEEX: alu_srcA=1, alu_srcB=00, subtract, pc_src=01.
  - BEQEX: pc_enab = zero.
  - BNEEX: pc_enab = !zero.
  - Both go to FETCH (retire).
- ADDIEX: alu_srcA=1, alu_srcB=10, add, then ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH (retire).
- JEX: pc_src=10, pc_enab=1, then FETCH (retire).
- ALU control encoding:
  - add=010, sub=110.
  - R-type funct: 100000 add, 100010 sub, 100100 and=000, 100101 or=001, 101010 slt=111.
  - Unknown funct drives 010; it is not a fault.
- Retire: instret increments by 1 on every transition into FETCH from a final state, and wraps modulo 2^CNT_W. Not counted: reset entry, hold cycles, FAULT.
- Timeout:
  - The counter clears on entry to any memory-wait state, and increments on each cycle with mem_req=1 and mem_ready=0.
  - When it reaches TIMEOUT: next state is FAULT.
  - mem_ready=1 on the same cycle the count reaches TIMEOUT is a completion, not a fault.
- FAULT: all strobes 0, fault=1. The only exit is reset.
- hold=1:
  - State, timeout counter and instret are frozen.
  - All write and enable strobes are forced to 0: ireg_enab, pc_enab, reg_write, mem_write.
  - mem_req is still held if a request is pending; mem_ready is ignored while hold=1.
- Multicycle-path signals (i_or_d, alu_src*, pc_src, mem_to_reg, reg_dst, alu_ctrl_sig) are Moore outputs of the current state.
- pc_enab and ireg_enab in FETCH and MEMRD/MEMWR are gated by mem_ready, so those strobes are Mealy.

Decomposition:
- Add to lib_cpu:
  - state enum MC_STATE
  - OPECODE values for ADDI (001000), J (000010), BNE (000101)
  - FUNCT values for R-type operations
  - ALU_CTRL localparams
- Sub-module alu_decoder: combinational mapping of (state class, funct) to alu_ctrl_sig.

Test Plan:
- Reset, then LW with mem_ready=1 immediately -> FETCH,DECODE,MEMADR,MEMRD,MEMWB, five cycles; reg_write=1 in cycle 5; instret=1.
- SW with mem_ready delayed 3 cycles in MEMWR -> mem_write=1 held for 4 cycles; state=FETCH on the next cycle.
- BNE with zero=0 -> pc_enab=1 and pc_src=01 in BNEEX; with zero=1 -> pc_enab=0; instret increments in both cases.
- TIMEOUT=4, mem_ready stuck 0 in FETCH -> FAULT entered after 4 wait cycles; fault=1; all strobes stay 0 until rst_n=0.
- hold=1 for 5 cycles mid-RTWB -> reg_write=0 throughout, state stays RTWB, and instret is unchanged. After release: one reg_write pulse, then FETCH.
- Unknown opcode 111111 in DECODE -> FAULT next cycle. With EN_EXT=0, ADDI -> FAULT.
